// File: rtl/ring_inject.sv
// ring_inject: ring injection stage feeding the tile's ring I/O control stage.
// Each cycle the upstream ring slot (Q499H) is registered into the Q500H slot.
// When the upstream slot is empty, the oldest pending local core request is
// taken from a small FIFO and placed in that slot instead. A saturating
// starvation counter flags a local request that has been blocked too long.
//
// Ports:
//   QClk, RstQnnnH                 clock, synchronous active-high reset
//   Ring*Q499H                     upstream ring slot (valid/opcode/address/data)
//   CoreReq*QnnnH                  local core request push interface (valid/ready)
//   Req*Q500H                      registered ring slot to the I/O control stage
//   InjectQ500H                    Q500H slot holds a locally injected request
//   FifoCountQnnnH                 core request FIFO occupancy
//   StarveQnnnH                    local request blocked for STARVE_CYCLES cycles

package ring_inject_pkg;
    typedef logic [3:0]  t_req_op;
    typedef logic [31:0] t_xlen;
endpackage

module ring_inject
    import ring_inject_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned STARVE_CYCLES = 16
) (
    input  logic                             QClk,
    input  logic                             RstQnnnH,
    input  logic                             RingValidQ499H,
    input  t_req_op                          RingOpcodeQ499H,
    input  t_xlen                            RingAddressQ499H,
    input  t_xlen                            RingDataQ499H,
    input  logic                             CoreReqValidQnnnH,
    output logic                             CoreReqReadyQnnnH,
    input  t_req_op                          CoreReqOpcodeQnnnH,
    input  t_xlen                            CoreReqAddressQnnnH,
    input  t_xlen                            CoreReqDataQnnnH,
    output logic                             ReqValidQ500H,
    output t_req_op                          ReqOpcodeQ500H,
    output t_xlen                            ReqAddressQ500H,
    output t_xlen                            ReqDataQ500H,
    output logic                             InjectQ500H,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  FifoCountQnnnH,
    output logic                             StarveQnnnH
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_CYCLES + 1);

    typedef struct packed {
        t_req_op opcode;
        t_xlen   address;
        t_xlen   data;
    } t_entry;

    t_entry             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [STV_W-1:0]   starve_cnt;
    logic [STV_W-1:0]   starve_next;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    t_entry             head;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

    // Ready ignores a same-cycle pop: a full FIFO refuses pushes regardless.
    assign CoreReqReadyQnnnH = !full && !RstQnnnH;
    assign FifoCountQnnnH    = count;

    assign push = CoreReqValidQnnnH && CoreReqReadyQnnnH;
    // Pop is based on the registered count, so an entry pushed this cycle
    // cannot be popped until the next one (no bypass path).
    assign pop  = !RingValidQ499H && !empty;
    assign head = mem[rd_ptr];

    // Storage is not reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge QClk) begin
        if (push) begin
            mem[wr_ptr] <= '{opcode: CoreReqOpcodeQnnnH,
                             address: CoreReqAddressQnnnH,
                             data: CoreReqDataQnnnH};
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (pop || empty) begin
            starve_next = '0;
        end else if (RingValidQ499H && (starve_cnt != STV_W'(STARVE_CYCLES))) begin
            starve_next = starve_cnt + STV_W'(1);
        end
    end

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            starve_cnt      <= '0;
            StarveQnnnH     <= 1'b0;
            ReqValidQ500H   <= 1'b0;
            ReqOpcodeQ500H  <= '0;
            ReqAddressQ500H <= '0;
            ReqDataQ500H    <= '0;
            InjectQ500H     <= 1'b0;
        end else begin
            // Power-of-two depth: pointers wrap naturally at PTR_W bits.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            starve_cnt  <= starve_next;
            StarveQnnnH <= (starve_next == STV_W'(STARVE_CYCLES));

            if (RingValidQ499H) begin
                ReqValidQ500H   <= 1'b1;
                ReqOpcodeQ500H  <= RingOpcodeQ499H;
                ReqAddressQ500H <= RingAddressQ499H;
                ReqDataQ500H    <= RingDataQ499H;
                InjectQ500H     <= 1'b0;
            end else if (pop) begin
                ReqValidQ500H   <= 1'b1;
                ReqOpcodeQ500H  <= head.opcode;
                ReqAddressQ500H <= head.address;
                ReqDataQ500H    <= head.data;
                InjectQ500H     <= 1'b1;
            end else begin
                ReqValidQ500H   <= 1'b0;
                ReqOpcodeQ500H  <= '0;
                ReqAddressQ500H <= '0;
                ReqDataQ500H    <= '0;
                InjectQ500H     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ring_inject.sv
// tb_ring_inject: directed, table-driven bench for ring_inject
// (FIFO_DEPTH = 4, STARVE_CYCLES = 16) plus hand-written starvation and
// reset-mid-operation sequences.

module tb_ring_inject;
    import ring_inject_pkg::*;

    logic        clk;
    logic        rst;
    logic        ring_valid;
    t_req_op     ring_op;
    t_xlen       ring_addr;
    t_xlen       ring_data;
    logic        core_valid;
    logic        core_ready;
    t_req_op     core_op;
    t_xlen       core_addr;
    t_xlen       core_data;
    logic        req_valid;
    t_req_op     req_op;
    t_xlen       req_addr;
    t_xlen       req_data;
    logic        inject;
    logic [2:0]  fifo_count;
    logic        starve;

    int unsigned errors = 0;
    int unsigned checks = 0;

    ring_inject #(
        .FIFO_DEPTH    (4),
        .STARVE_CYCLES (16)
    ) dut (
        .QClk                (clk),
        .RstQnnnH            (rst),
        .RingValidQ499H      (ring_valid),
        .RingOpcodeQ499H     (ring_op),
        .RingAddressQ499H    (ring_addr),
        .RingDataQ499H       (ring_data),
        .CoreReqValidQnnnH   (core_valid),
        .CoreReqReadyQnnnH   (core_ready),
        .CoreReqOpcodeQnnnH  (core_op),
        .CoreReqAddressQnnnH (core_addr),
        .CoreReqDataQnnnH    (core_data),
        .ReqValidQ500H       (req_valid),
        .ReqOpcodeQ500H      (req_op),
        .ReqAddressQ500H     (req_addr),
        .ReqDataQ500H        (req_data),
        .InjectQ500H         (inject),
        .FifoCountQnnnH      (fifo_count),
        .StarveQnnnH         (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rd;
        logic        cv;
        logic [3:0]  cop;
        logic [31:0] ca;
        logic [31:0] cd;
        logic        ev;
        logic [3:0]  eop;
        logic [31:0] ea;
        logic [31:0] ed;
        logic        einj;
        logic [2:0]  ecnt;
        logic        erdy;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    function automatic vec_t v(logic r, logic rv, logic [3:0] rop, logic [31:0] ra, logic [31:0] rd,
                               logic cv, logic [3:0] cop, logic [31:0] ca, logic [31:0] cd,
                               logic ev, logic [3:0] eop, logic [31:0] ea, logic [31:0] ed,
                               logic einj, logic [2:0] ecnt, logic erdy);
        vec_t x;
        x.rst = r;   x.rv = rv;   x.rop = rop; x.ra = ra; x.rd = rd;
        x.cv = cv;   x.cop = cop; x.ca = ca;   x.cd = cd;
        x.ev = ev;   x.eop = eop; x.ea = ea;   x.ed = ed;
        x.einj = einj; x.ecnt = ecnt; x.erdy = erdy;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rv, input logic [3:0] rop, input logic [31:0] ra,
                         input logic [31:0] rd, input logic cv, input logic [3:0] cop,
                         input logic [31:0] ca, input logic [31:0] cd);
        rst = r; ring_valid = rv; ring_op = rop; ring_addr = ra; ring_data = rd;
        core_valid = cv; core_op = cop; core_addr = ca; core_data = cd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic ev, input logic [3:0] eop,
                            input logic [31:0] ea, input logic [31:0] ed, input logic einj);
        chk({tag, ".valid"},  64'(req_valid), 64'(ev));
        chk({tag, ".opcode"}, 64'(req_op),    64'(eop));
        chk({tag, ".addr"},   64'(req_addr),  64'(ea));
        chk({tag, ".data"},   64'(req_data),  64'(ed));
        chk({tag, ".inject"}, 64'(inject),    64'(einj));
    endtask

    initial begin
        // Entry Ei: op 8, addr 0x1000+i, data 0xC0DE0000+i.
        // Ring slot rk: op 1, addr 0x100+k, data 0xFFFF0000+k.
        tbl[0]  = v(1, 0,4'h0,32'h0,32'h0,                 0,4'h0,32'h0,32'h0,
                    0,4'h0,32'h0,32'h0, 0, 3'd0, 0);
        tbl[1]  = v(0, 1,4'h2,32'h0040_0010,32'hDEAD_BEEF, 0,4'h0,32'h0,32'h0,
                    1,4'h2,32'h0040_0010,32'hDEAD_BEEF, 0, 3'd0, 1);
        tbl[2]  = v(0, 0,4'h0,32'h0,32'h0,                 1,4'h5,32'h1234_5678,32'hA5A5_A5A5,
                    0,4'h0,32'h0,32'h0, 0, 3'd1, 1);
        tbl[3]  = v(0, 0,4'h0,32'h0,32'h0,                 0,4'h0,32'h0,32'h0,
                    1,4'h5,32'h1234_5678,32'hA5A5_A5A5, 1, 3'd0, 1);
        tbl[4]  = v(0, 0,4'h0,32'h0,32'h0,                 0,4'h0,32'h0,32'h0,
                    0,4'h0,32'h0,32'h0, 0, 3'd0, 1);
        tbl[5]  = v(0, 1,4'h1,32'h100,32'hFFFF_0000,       1,4'h8,32'h1000,32'hC0DE_0000,
                    1,4'h1,32'h100,32'hFFFF_0000, 0, 3'd1, 1);
        tbl[6]  = v(0, 1,4'h1,32'h101,32'hFFFF_0001,       1,4'h8,32'h1001,32'hC0DE_0001,
                    1,4'h1,32'h101,32'hFFFF_0001, 0, 3'd2, 1);
        tbl[7]  = v(0, 1,4'h1,32'h102,32'hFFFF_0002,       1,4'h8,32'h1002,32'hC0DE_0002,
                    1,4'h1,32'h102,32'hFFFF_0002, 0, 3'd3, 1);
        tbl[8]  = v(0, 1,4'h1,32'h103,32'hFFFF_0003,       1,4'h8,32'h1003,32'hC0DE_0003,
                    1,4'h1,32'h103,32'hFFFF_0003, 0, 3'd4, 0);
        // Fifth push offered while full: refused.
        tbl[9]  = v(0, 1,4'h1,32'h104,32'hFFFF_0004,       1,4'h8,32'h1004,32'hC0DE_0004,
                    1,4'h1,32'h104,32'hFFFF_0004, 0, 3'd4, 0);
        tbl[10] = v(0, 0,4'h0,32'h0,32'h0,                 0,4'h0,32'h0,32'h0,
                    1,4'h8,32'h1000,32'hC0DE_0000, 1, 3'd3, 1);
        tbl[11] = v(0, 0,4'h0,32'h0,32'h0,                 0,4'h0,32'h0,32'h0,
                    1,4'h8,32'h1001,32'hC0DE_0001, 1, 3'd2, 1);
        // Simultaneous push/pop at count 2.
        tbl[12] = v(0, 0,4'h0,32'h0,32'h0,                 1,4'h8,32'h1005,32'hC0DE_0005,
                    1,4'h8,32'h1002,32'hC0DE_0002, 1, 3'd2, 1);
        tbl[13] = v(0, 0,4'h0,32'h0,32'h0,                 1,4'h8,32'h1006,32'hC0DE_0006,
                    1,4'h8,32'h1003,32'hC0DE_0003, 1, 3'd2, 1);
        tbl[14] = v(0, 0,4'h0,32'h0,32'h0,                 1,4'h8,32'h1007,32'hC0DE_0007,
                    1,4'h8,32'h1005,32'hC0DE_0005, 1, 3'd2, 1);
        tbl[15] = v(0, 0,4'h0,32'h0,32'h0,                 1,4'h8,32'h1008,32'hC0DE_0008,
                    1,4'h8,32'h1006,32'hC0DE_0006, 1, 3'd2, 1);
        tbl[16] = v(0, 0,4'h0,32'h0,32'h0,                 0,4'h0,32'h0,32'h0,
                    1,4'h8,32'h1007,32'hC0DE_0007, 1, 3'd1, 1);
        tbl[17] = v(0, 0,4'h0,32'h0,32'h0,                 0,4'h0,32'h0,32'h0,
                    1,4'h8,32'h1008,32'hC0DE_0008, 1, 3'd0, 1);
        tbl[18] = v(0, 0,4'h0,32'h0,32'h0,                 0,4'h0,32'h0,32'h0,
                    0,4'h0,32'h0,32'h0, 0, 3'd0, 1);

        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].rst, tbl[i].rv, tbl[i].rop, tbl[i].ra, tbl[i].rd,
                  tbl[i].cv, tbl[i].cop, tbl[i].ca, tbl[i].cd);
            tick();
            chk_slot(tag, tbl[i].ev, tbl[i].eop, tbl[i].ea, tbl[i].ed, tbl[i].einj);
            chk({tag, ".count"},  64'(fifo_count), 64'(tbl[i].ecnt));
            chk({tag, ".ready"},  64'(core_ready), 64'(tbl[i].erdy));
            chk({tag, ".starve"}, 64'(starve),     64'(1'b0));
        end

        // Starvation: one entry pending behind a busy ring.
        drive(0, 1, 4'h3, 32'h200, 32'h2222_0000, 1, 4'h9, 32'h3000, 32'h5555_AAAA);
        tick();
        chk("stv.push.count", 64'(fifo_count), 64'd1);
        chk("stv.push.starve", 64'(starve), 64'd0);
        drive(0, 1, 4'h3, 32'h200, 32'h2222_0000, 0, 4'h0, 32'h0, 32'h0);
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk($sformatf("stv.blocked%0d", k), 64'(starve), 64'(k >= 16));
        end
        chk("stv.hold.count", 64'(fifo_count), 64'd1);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        chk_slot("stv.inject", 1'b1, 4'h9, 32'h3000, 32'h5555_AAAA, 1'b1);
        chk("stv.clear", 64'(starve), 64'd0);
        chk("stv.count", 64'(fifo_count), 64'd0);

        // Reset mid-operation: three entries pending, ring slot in reset cycle.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 4'h4, 32'h400 + k, 32'h4444_0000 + k, 1, 4'hA, 32'h5000 + k, 32'h6666_0000 + k);
            tick();
        end
        chk("rst.pre.count", 64'(fifo_count), 64'd3);
        drive(1, 1, 4'h7, 32'h777, 32'h7777_7777, 1, 4'hB, 32'h5555, 32'h5555_5555);
        tick();
        chk_slot("rst.during", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        chk("rst.during.count", 64'(fifo_count), 64'd0);
        chk("rst.during.ready", 64'(core_ready), 64'd0);
        chk("rst.during.starve", 64'(starve), 64'd0);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("rst.release.ready", 64'(core_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_slot($sformatf("rst.after%0d", k), 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
            chk($sformatf("rst.after%0d.count", k), 64'(fifo_count), 64'd0);
        end
        // Pass-through resumes straight after reset.
        drive(0, 1, 4'hC, 32'h0BAD_F00D, 32'h1357_9BDF, 0, 4'h0, 32'h0, 32'h0);
        tick();
        chk_slot("rst.ring", 1'b1, 4'hC, 32'h0BAD_F00D, 32'h1357_9BDF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ring_inject.md
# ring_inject

Ring injection stage directly upstream of the tile's ring I/O control stage. Each cycle it registers the incoming ring slot (Q499H) into the Q500H request slot. When the incoming slot is empty, it fills that slot with a pending local core request taken from a small FIFO. A starvation counter flags when local requests have waited too long for a free slot.

## Interface
Parameters:
- FIFO_DEPTH, default 4: core request FIFO entries; power of 2, at least 2.
- STARVE_CYCLES, default 16: number of consecutive blocked cycles at which StarveQnnnH asserts; at least 1.

Ports:
- QClk  in  1  single clock; all state updates on its rising edge.
- RstQnnnH  in  1  synchronous, active-high reset.
- RingValidQ499H  in  1  upstream ring slot occupied.
- RingOpcodeQ499H  in  t_req_op  upstream ring opcode.
- RingAddressQ499H  in  t_xlen  upstream ring address.
- RingDataQ499H  in  t_xlen  upstream ring data.
- CoreReqValidQnnnH  in  1  local core request valid.
- CoreReqReadyQnnnH  out  1  FIFO can accept a request.
- CoreReqOpcodeQnnnH  in  t_req_op  core request opcode.
- CoreReqAddressQnnnH  in  t_xlen  core request address.
- CoreReqDataQnnnH  in  t_xlen  core request data.
- ReqValidQ500H  out  1  ring slot valid, to the I/O control stage.
- ReqOpcodeQ500H  out  t_req_op  ring slot opcode.
- ReqAddressQ500H  out  t_xlen  ring slot address.
- ReqDataQ500H  out  t_xlen  ring slot data.
- InjectQ500H  out  1  the Q500H slot holds a locally injected request.
- FifoCountQnnnH  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- StarveQnnnH  out  1  a local request has been blocked for STARVE_CYCLES cycles.

## Operation
- Core push: a push occurs when CoreReqValidQnnnH && CoreReqReadyQnnnH. The entry {opcode, address, data} is written at the write pointer.
- Ready rule: CoreReqReadyQnnnH = !full && !RstQnnnH.
- Ready does not depend on a same-cycle pop. When the FIFO is full, a push is refused even if a pop occurs in the same cycle.
- Ring pass-through: when RingValidQ499H = 1, the incoming slot is registered to Q500H unchanged and InjectQ500H = 0. The ring always has priority.
- Injection: when RingValidQ499H = 0 and the FIFO is non-empty, the head entry is popped. It appears on Q500H next cycle with ReqValidQ500H = 1 and InjectQ500H = 1.
- Idle: when RingValidQ499H = 0 and the FIFO is empty, ReqValidQ500H = 0 and InjectQ500H = 0. Opcode, address and data outputs are 0.
- No bypass: a pushed entry can be popped no earlier than the cycle after its push. This holds even if the FIFO was empty and the ring slot is free in the push cycle.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a separate counter.
- Occupancy update: the count goes +1 on push only, -1 on pop only, and is unchanged on simultaneous push and pop.
- Starvation counter:
  - Increments, saturating at STARVE_CYCLES, in each cycle the FIFO is non-empty and RingValidQ499H = 1 (pop blocked).
  - Clears to 0 on any pop, and in any cycle the FIFO is empty.
  - Holds otherwise.
  - StarveQnnnH = (counter == STARVE_CYCLES). It is registered and does not block pushes.
- Opcode handling: opcodes are opaque; no field is decoded.

## Timing
- Ring Q499H to Q500H latency: exactly 1 cycle.
- Core push to earliest Q500H appearance: 2 cycles (push at cycle N, pop at N+1, valid at N+2).
- Output registers: ReqValidQ500H, the opcode/address/data outputs, InjectQ500H and StarveQnnnH are registered.
- Combinational outputs: CoreReqReadyQnnnH, and FifoCountQnnnH taken from the registered count.
- Reset (synchronous, while RstQnnnH = 1 at the edge):
  - All Q500H outputs, InjectQ500H, StarveQnnnH, FifoCountQnnnH, pointers and the starvation counter go to 0.
  - FIFO contents are discarded.
  - CoreReqReadyQnnnH is 0 while reset is asserted.
- Reset mid-operation: pending entries are lost, with no injection in the cycle after reset. A ring slot presented in the reset cycle is dropped.
- First cycle after reset deassertion: CoreReqReadyQnnnH = 1; ring pass-through resumes that cycle.

## Test plan
- Pass-through: ring slot {valid=1, addr=0x0040_0010, data=0xDEAD_BEEF} at cycle N with the FIFO empty -> the same fields on Q500H at N+1, InjectQ500H = 0, FifoCountQnnnH = 0.
- Injection latency: push {addr=0x1234_5678, data=0xA5A5_A5A5} at N with the ring idle -> nothing on Q500H at N+1; valid with InjectQ500H = 1 and those fields at N+2; count returns to 0.
- Full FIFO, ring busy, FIFO_DEPTH = 4:
  - Ring busy, pushes 0..4 -> count = 4 after the fourth push; ready = 0; the fifth push is refused.
  - Ring frees -> entries emerge in order 0..3 on consecutive cycles.
- Simultaneous push and pop at count = 2 -> count stays 2; FIFO order preserved; pointer wrap is exercised after 8 total pushes.
- Starvation, STARVE_CYCLES = 16:
  - One pending entry with the ring busy for 16 consecutive cycles -> StarveQnnnH = 1 from the 16th blocked cycle on and stays 1.
  - One ring-idle cycle -> the entry is injected and StarveQnnnH = 0 the following cycle.
- Reset mid-operation: count = 3 and a ring slot valid, then assert RstQnnnH for 1 cycle -> all outputs 0 and count = 0; ready = 1 after deassertion; no stale entry is ever injected.
